// File: rtl/merge_arb2_pkg.sv
// Shared types for the 2:1 round-robin merger: beat width, source index and buffered beat.
// Pure declarations; no timing or flow control of its own.
package merge_pkg;

   localparam int DATA_W = 8;

   typedef logic src_t;

   typedef struct packed {
      src_t              src;
      logic [DATA_W-1:0] data;
   } beat_t;

endpackage

// File: rtl/merge_arb2_if.sv
// Source/consumer handshake bundle for merge_arb2; slave is the merger, master drives it.
// Valid/ready on both sides; the merger never ties out_ready to in*_ready.
interface merge_arb2_if;
   import merge_pkg::*;

   logic [DATA_W-1:0] in0_data;
   logic              in0_valid;
   logic              in0_ready;
   logic [DATA_W-1:0] in1_data;
   logic              in1_valid;
   logic              in1_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_valid;
   logic              out_ready;

   modport slave (
      input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
      output in0_ready, in1_ready, out_data, out_src, out_valid
   );

   modport master (
      output in0_data, in0_valid, in1_data, in1_valid, out_ready,
      input  in0_ready, in1_ready, out_data, out_src, out_valid
   );

endinterface

// File: rtl/merge_arb2_fifo2.sv
// Two-entry beat FIFO; write visible at the head one cycle later, read data straight from storage.
// Caller must not write when full or read when empty; full/empty come from registered count only.
module merge_fifo2
   import merge_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  wr_en,
   input  beat_t wr_beat,
   input  logic  rd_en,
   output beat_t rd_beat,
   output logic  full,
   output logic  empty
);

   beat_t      mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_beat;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (rd_en) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Head is shown even when empty; the stale entry is harmless to the consumer.
   assign rd_beat = mem_q[rd_ptr_q];
   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);

endmodule

// File: rtl/merge_arb2.sv
// Round-robin 2:1 merger tagging each beat with its source; accept-to-out_valid latency is 1 cycle.
// Readies drop while the 2-entry buffer is full, independent of out_ready; non-granted input waits.
module merge_arb2
   import merge_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   merge_arb2_if.slave      bus
);

   logic  rr_q;
   logic  rr_d;
   logic  grant_vld;
   src_t  grant_src;
   logic  rdy_ok;
   logic  acc;
   logic  pop;
   logic  full;
   logic  empty;
   beat_t wr_beat;
   beat_t rd_beat;

   always_comb begin
      grant_vld = bus.in0_valid | bus.in1_valid;
      grant_src = (bus.in0_valid && bus.in1_valid) ? rr_q : bus.in1_valid;
      // Gating with rst_n keeps both readies low while reset is held.
      rdy_ok    = rst_n & ~full;
      acc       = rdy_ok & grant_vld;
      wr_beat   = '{src: grant_src, data: (grant_src ? bus.in1_data : bus.in0_data)};
      pop       = ~empty & bus.out_ready;
      rr_d      = acc ? ~grant_src : rr_q;
   end

   assign bus.in0_ready = acc & (grant_src == 1'b0);
   assign bus.in1_ready = acc & (grant_src == 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   merge_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (acc),
      .wr_beat (wr_beat),
      .rd_en   (pop),
      .rd_beat (rd_beat),
      .full    (full),
      .empty   (empty)
   );

   assign bus.out_valid = ~empty;
   assign bus.out_data  = rd_beat.data;
   assign bus.out_src   = rd_beat.src;

endmodule
